cond_flag_unit: RTL and testbench
=================================

// Module: cond_flag_unit
// PURPOSE
//  Consumer end of the ALU status interface: latches ALU Zero/Negative/Overflow/Co into the NZCV register on flag-setting ops (ADDS/SUBS/ANDS).
//  Evaluates LEGv8 B.cond condition codes against NZCV and returns registered taken/not-taken through a valid/ready result channel.
//  Sits beside the EX-stage ALU; its result channel feeds PC-select/branch resolution.
// PARAMETERS
//  FLAG_BYPASS  1        1: a condition accepted in the same cycle as flag_we sees the new ALU flags; 0: sees the old NZCV
//  RESET_NZCV   4'b0000  NZCV value after reset, ordered {N,Z,C,V}
// PORTS
//  clk           in   1  system clock, rising edge
//  rst_n         in   1  asynchronous active-low reset
//  flag_we       in   1  EX instruction sets flags this cycle
//  alu_negative  in   1  ALU Negative flag
//  alu_zero      in   1  ALU Zero flag
//  alu_co        in   1  ALU carry-out flag
//  alu_overflow  in   1  ALU Overflow flag
//  flush         in   1  pipeline flush (wrong-path squash)
//  cond_valid    in   1  condition-evaluation request valid
//  cond_ready    out  1  unit can accept a request
//  cond_code     in   4  B.cond code, sampled on accept
//  res_valid     out  1  result valid, held until consumed
//  res_ready     in   1  consumer takes the result
//  res_taken     out  1  1 = condition true; meaningful only while res_valid
//  nzcv          out  4  current flag register {N,Z,C,V}
// BEHAVIOUR
//  Reset (async, rst_n=0): nzcv=RESET_NZCV, res_valid=0, res_taken=0. cond_ready is 1 during reset and afterwards because res_valid=0.
//  Flag write: on a clk edge with flag_we=1 and flush=0, nzcv <= {alu_negative,alu_zero,alu_co,alu_overflow}. Otherwise nzcv holds.
//  Effective flags for evaluation: FLAG_BYPASS=1 and flag_we=1 and flush=0 -> the incoming ALU flags; otherwise the nzcv register.
//  Handshake: cond_ready = !res_valid | res_ready (combinational). A request is accepted when cond_valid & cond_ready & !flush.
//  Latency: the result is registered. res_valid rises on the edge after accept, so the result is visible 1 cycle after acceptance.
//  Result register:
//   - accept: res_valid<=1 and res_taken<=eval(cond_code).
//   - res_valid & res_ready without an accept: res_valid<=0.
//   - accept and consume in the same cycle: the new result replaces the old one, so back-to-back throughput is 1/cycle.
//   - res_valid & !res_ready: the result holds and cond_ready=0.
//  eval(code), with N,Z,C,V being the effective flags:
//   0 EQ Z | 1 NE !Z | 2 HS C | 3 LO !C | 4 MI N | 5 PL !N | 6 VS V | 7 VC !V
//   8 HI C&!Z | 9 LS !C|Z | 10 GE N==V | 11 LT N!=V | 12 GT !Z&(N==V) | 13 LE Z|(N!=V)
//   14 AL 1 | 15 NV 1
//  Flush has priority over every same-cycle event. On the edge where flush=1:
//   - res_valid<=0, so any held result is discarded.
//   - A same-cycle request is not accepted.
//   - A same-cycle flag_we is ignored and nzcv holds.
//   cond_ready still follows its equation while flush=1. A requester must not treat a handshake made during flush as accepted.
//  Reset mid-operation: all state returns to reset values immediately and the pending result is lost.
//  Fully synchronous except reset. No combinational path from cond_valid to cond_ready. Only one result is outstanding at a time.
// TESTING
//  1 Reset: rst_n=0 mid-cycle while res_valid=1 -> res_valid=0 and nzcv=0000 immediately; after release cond_ready=1.
//  2 Flag write and EQ: flag_we=1 with zero=1, other flags 0, then cond_code=0 accepted next cycle
//    -> nzcv=0100, res_valid=1 one cycle after accept, res_taken=1; cond_code=1 -> res_taken=0.
//  3 Bypass: nzcv=0000, same cycle flag_we=1 with N=1,V=0 and cond_code=11 (LT) accepted
//    -> FLAG_BYPASS=1 gives res_taken=1; FLAG_BYPASS=0 gives res_taken=0.
//  4 Back-pressure: res_valid=1 and res_ready=0 for 3 cycles with cond_valid=1 -> cond_ready=0, result stable, no accept;
//    res_ready=1 -> same-cycle accept, new result on the next edge.
//  5 Flush: flush=1 together with flag_we=1 (Z=1), cond_valid=1 and a held result -> nzcv unchanged, res_valid=0 next cycle, no new result.
//  6 Signed conditions sweep: NZCV in {1001,0000,0100,1000} x codes 8-15 -> res_taken matches the eval table
//    (e.g. NZCV=1001: GE=1, GT=1, LE=0).

Source files
------------

// File: rtl/cond_flag_unit.sv
// NZCV flag register plus registered B.cond evaluator with a valid/ready result channel.
// Flush squashes the same-cycle flag write, request and any held result.
module cond_flag_unit #(
  parameter bit         FLAG_BYPASS = 1'b1,
  parameter logic [3:0] RESET_NZCV  = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_we,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_co,
  input  logic       alu_overflow,
  input  logic       flush,
  input  logic       cond_valid,
  output logic       cond_ready,
  input  logic [3:0] cond_code,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_taken,
  output logic [3:0] nzcv
);

  logic [3:0] nzcv_q, nzcv_d;
  logic       res_valid_q, res_valid_d;
  logic       res_taken_q, res_taken_d;
  logic [3:0] alu_flags, eff_flags;
  logic       flag_wr, accept;

  // Flags ordered {N,Z,C,V}
  function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (code)
      4'd0:    eval_cond = z;
      4'd1:    eval_cond = !z;
      4'd2:    eval_cond = c;
      4'd3:    eval_cond = !c;
      4'd4:    eval_cond = n;
      4'd5:    eval_cond = !n;
      4'd6:    eval_cond = v;
      4'd7:    eval_cond = !v;
      4'd8:    eval_cond = c & !z;
      4'd9:    eval_cond = !c | z;
      4'd10:   eval_cond = (n == v);
      4'd11:   eval_cond = (n != v);
      4'd12:   eval_cond = !z & (n == v);
      4'd13:   eval_cond = z | (n != v);
      default: eval_cond = 1'b1;
    endcase
  endfunction

  always_comb begin
    alu_flags  = {alu_negative, alu_zero, alu_co, alu_overflow};
    flag_wr    = flag_we & !flush;
    eff_flags  = (FLAG_BYPASS && flag_wr) ? alu_flags : nzcv_q;
    // Depends only on registered state and res_ready, never on cond_valid
    cond_ready = !res_valid_q | res_ready;
    accept     = cond_valid & cond_ready & !flush;
  end

  always_comb begin
    nzcv_d      = nzcv_q;
    res_valid_d = res_valid_q;
    res_taken_d = res_taken_q;
    if (flag_wr) begin
      nzcv_d = alu_flags;
    end
    if (flush) begin
      res_valid_d = 1'b0;
    end else if (accept) begin
      res_valid_d = 1'b1;
      res_taken_d = eval_cond(cond_code, eff_flags);
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_q      <= RESET_NZCV;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
    end else begin
      nzcv_q      <= nzcv_d;
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
    end
  end

  assign nzcv      = nzcv_q;
  assign res_valid = res_valid_q;
  assign res_taken = res_taken_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit; a second instance with FLAG_BYPASS=0 shares all inputs.
module tb_cond_flag_unit;

  logic       clk;
  logic       rst_n;
  logic       flag_we, alu_negative, alu_zero, alu_co, alu_overflow;
  logic       flush, cond_valid, res_ready;
  logic [3:0] cond_code;
  logic       cond_ready, res_valid, res_taken;
  logic [3:0] nzcv;
  logic       nb_cond_ready, nb_res_valid, nb_res_taken;
  logic [3:0] nb_nzcv;
  int         checks;
  int         errors;

  cond_flag_unit #(.FLAG_BYPASS(1'b1), .RESET_NZCV(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .alu_negative(alu_negative),
    .alu_zero(alu_zero), .alu_co(alu_co), .alu_overflow(alu_overflow), .flush(flush),
    .cond_valid(cond_valid), .cond_ready(cond_ready), .cond_code(cond_code),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken), .nzcv(nzcv)
  );

  cond_flag_unit #(.FLAG_BYPASS(1'b0), .RESET_NZCV(4'b0000)) dut_nb (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .alu_negative(alu_negative),
    .alu_zero(alu_zero), .alu_co(alu_co), .alu_overflow(alu_overflow), .flush(flush),
    .cond_valid(cond_valid), .cond_ready(nb_cond_ready), .cond_code(cond_code),
    .res_valid(nb_res_valid), .res_ready(res_ready), .res_taken(nb_res_taken),
    .nzcv(nb_nzcv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    {alu_negative, alu_zero, alu_co, alu_overflow} = f;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (nzcv !== 4'b0000 || res_valid !== 1'b0 || cond_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_init: nzcv=%b valid=%b ready=%b, want 0000 0 1",
               nzcv, res_valid, cond_ready);
    end
    #4 rst_n = 1'b1;
    step();
    // Build up state: nzcv=1111 and a held result
    flag_we = 1'b1; set_flags(4'b1111);
    cond_valid = 1'b1; cond_code = 4'd14; res_ready = 1'b0;
    step();
    flag_we = 1'b0; cond_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || nzcv !== 4'b1111) begin
      errors++;
      $display("FAIL reset_setup: valid=%b nzcv=%b, want 1 1111", res_valid, nzcv);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || nzcv !== 4'b0000 || res_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: valid=%b nzcv=%b taken=%b, want 0 0000 0",
               res_valid, nzcv, res_taken);
    end
    checks++;
    if (cond_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_during: got %b want 1", cond_ready);
    end
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (cond_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b, want 1 0", cond_ready, res_valid);
    end
  endtask

  task automatic test_flag_eq();
    res_ready = 1'b1;
    flag_we = 1'b1; set_flags(4'b0100);
    step();
    flag_we = 1'b0; set_flags(4'b0000);
    checks++;
    if (nzcv !== 4'b0100) begin
      errors++;
      $display("FAIL flag_write: nzcv=%b want 0100", nzcv);
    end
    cond_valid = 1'b1; cond_code = 4'd0;
    #1;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL eq_not_early: valid=%b want 0", res_valid);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || res_taken !== 1'b1) begin
      errors++;
      $display("FAIL eq_taken: valid=%b taken=%b, want 1 1", res_valid, res_taken);
    end
    cond_code = 4'd1;
    step();
    checks++;
    if (res_valid !== 1'b1 || res_taken !== 1'b0) begin
      errors++;
      $display("FAIL ne_taken: valid=%b taken=%b, want 1 0", res_valid, res_taken);
    end
    cond_valid = 1'b0;
    step();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL consume_clears: valid=%b want 0", res_valid);
    end
  endtask

  task automatic test_bypass();
    res_ready = 1'b1;
    flag_we = 1'b1; set_flags(4'b0000);
    step();
    set_flags(4'b1000);
    cond_valid = 1'b1; cond_code = 4'd11;
    step();
    flag_we = 1'b0; cond_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_taken !== 1'b1) begin
      errors++;
      $display("FAIL bypass_on_lt: valid=%b taken=%b, want 1 1", res_valid, res_taken);
    end
    checks++;
    if (nb_res_valid !== 1'b1 || nb_res_taken !== 1'b0) begin
      errors++;
      $display("FAIL bypass_off_lt: valid=%b taken=%b, want 1 0", nb_res_valid, nb_res_taken);
    end
    checks++;
    if (nzcv !== 4'b1000 || nb_nzcv !== 4'b1000) begin
      errors++;
      $display("FAIL bypass_nzcv: nzcv=%b/%b want 1000", nzcv, nb_nzcv);
    end
    step();
  endtask

  task automatic test_backpressure();
    // nzcv=1000 from previous test
    res_ready = 1'b0; cond_valid = 1'b1; cond_code = 4'd14;
    step();
    checks++;
    if (res_valid !== 1'b1 || res_taken !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: valid=%b taken=%b, want 1 1", res_valid, res_taken);
    end
    cond_code = 4'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (cond_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready_low[%0d]: got %b want 0", i, cond_ready);
      end
      step();
      checks++;
      if (res_valid !== 1'b1 || res_taken !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b taken=%b, want 1 1", i, res_valid, res_taken);
      end
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (cond_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 1", cond_ready);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || res_taken !== 1'b0) begin
      errors++;
      $display("FAIL bp_replace: valid=%b taken=%b, want 1 0", res_valid, res_taken);
    end
    cond_valid = 1'b0;
    step();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b want 0", res_valid);
    end
  endtask

  task automatic test_flush();
    res_ready = 1'b0; cond_valid = 1'b1; cond_code = 4'd14;
    step();
    flush = 1'b1; flag_we = 1'b1; set_flags(4'b0100);
    cond_code = 4'd0;
    #1;
    checks++;
    if (cond_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready_eq: got %b want 0", cond_ready);
    end
    step();
    flush = 1'b0; flag_we = 1'b0; cond_valid = 1'b0; set_flags(4'b0000);
    checks++;
    if (nzcv !== 4'b1000) begin
      errors++;
      $display("FAIL flush_nzcv_hold: nzcv=%b want 1000", nzcv);
    end
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_discard: valid=%b want 0", res_valid);
    end
    step();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_accept: valid=%b want 0", res_valid);
    end
    // Flush with empty result register and ready consumer must still block accept
    res_ready = 1'b1; flush = 1'b1; cond_valid = 1'b1; cond_code = 4'd14;
    step();
    flush = 1'b0; cond_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_block_empty: valid=%b want 0", res_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  nz_tbl [5];
    logic [15:0] exp_tbl [5];
    logic [15:0] row;
    nz_tbl[0] = 4'b1001; exp_tbl[0] = 16'hD65A;
    nz_tbl[1] = 4'b0000; exp_tbl[1] = 16'hD6AA;
    nz_tbl[2] = 4'b0100; exp_tbl[2] = 16'hE6A9;
    nz_tbl[3] = 4'b1000; exp_tbl[3] = 16'hEA9A;
    nz_tbl[4] = 4'b0010; exp_tbl[4] = 16'hD5A6;
    res_ready = 1'b1;
    for (int s = 0; s < 5; s++) begin
      flag_we = 1'b1; set_flags(nz_tbl[s]); cond_valid = 1'b0;
      step();
      flag_we = 1'b0; set_flags(4'b0000);
      row = exp_tbl[s];
      // One request per cycle, each result checked the cycle after its accept
      for (int c = 0; c < 16; c++) begin
        cond_valid = 1'b1; cond_code = 4'(c);
        step();
        checks++;
        if (res_valid !== 1'b1 || res_taken !== row[c] || nb_res_taken !== row[c]) begin
          errors++;
          $display("FAIL sweep nzcv=%b code=%0d: valid=%b taken=%b/%b, want 1 %b",
                   nz_tbl[s], c, res_valid, res_taken, nb_res_taken, row[c]);
        end
      end
      cond_valid = 1'b0;
      step();
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    flag_we = 1'b0; set_flags(4'b0000);
    flush = 1'b0; cond_valid = 1'b0; cond_code = 4'd0; res_ready = 1'b0;
    test_reset();
    test_flag_eq();
    test_bypass();
    test_backpressure();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
